// File: rtl/val2_pkg.sv
// Shared encodings and the stage-1 record for the Val2 shift unit.
package val2_pkg;

  // Amount field is wide enough to express "shift by DATA_W" for any supported width.
  localparam int AMT_W = 16;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  localparam logic [1:0] MODE_MEM = 2'd0;
  localparam logic [1:0] MODE_IMM = 2'd1;
  localparam logic [1:0] MODE_REG = 2'd2;
  localparam logic [1:0] MODE_ISH = 2'd3;

  typedef struct packed {
    logic [1:0]       mode;
    logic [1:0]       sh_type;
    logic [AMT_W-1:0] amount;
    logic             cin;
  } s1_ctrl_t;

  function automatic logic [1:0] decode_mode(input logic mem_en, input logic imm,
                                             input logic reg_shift);
    if (mem_en) return MODE_MEM;
    if (imm) return MODE_IMM;
    if (reg_shift) return MODE_REG;
    return MODE_ISH;
  endfunction

endpackage

// File: rtl/val2_shift_unit_barrel.sv
// Combinational ARM-style barrel shifter: LSL/LSR/ASR/ROR with carry-out, log2 levels.
module barrel_shift_core
  import val2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] value,
  input  logic [AMT_W-1:0]  amount,
  input  logic [1:0]        sh_type,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam int LG = $clog2(DATA_W);

  logic              is_lsl;
  logic              fill;
  logic [LG:0]       sat;
  logic [DATA_W-1:0] value_rev;
  logic [DATA_W:0]   rsh_in;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] shifted_rev;
  logic [DATA_W-1:0] shift_result;
  logic              shift_carry;
  logic [DATA_W-1:0] rot_result;

  assign is_lsl = (sh_type == SH_LSL);
  assign fill   = (sh_type == SH_ASR) & value[DATA_W-1];
  // Any amount beyond DATA_W behaves like DATA_W+1: everything, carry included, is shifted out.
  assign sat    = (amount > AMT_W'(DATA_W)) ? (LG+1)'(DATA_W + 1) : amount[LG:0];

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign value_rev[gi]   = value[DATA_W-1-gi];
      assign shifted_rev[gi] = shifted[DATA_W-1-gi];
    end
  endgenerate

  // LSL runs through the right shifter bit-reversed; the extra LSB catches the carry-out.
  assign rsh_in = {(is_lsl ? value_rev : value), 1'b0};

  generate
    for (gi = 0; gi <= LG; gi++) begin : g_rsh
      logic [DATA_W:0] prev;
      logic [DATA_W:0] stage;
      if (gi == 0) begin : g_first
        assign prev = rsh_in;
      end else begin : g_next
        assign prev = g_rsh[gi-1].stage;
      end
      assign stage = sat[gi] ? {{(2**gi){fill}}, prev[DATA_W:2**gi]} : prev;
    end
  endgenerate

  assign shifted      = g_rsh[LG].stage[DATA_W:1];
  assign shift_carry  = g_rsh[LG].stage[0];
  assign shift_result = is_lsl ? shifted_rev : shifted;

  generate
    for (gi = 0; gi < LG; gi++) begin : g_rot
      logic [DATA_W-1:0] prev;
      logic [DATA_W-1:0] stage;
      if (gi == 0) begin : g_first
        assign prev = value;
      end else begin : g_next
        assign prev = g_rot[gi-1].stage;
      end
      assign stage = amount[gi] ? {prev[(2**gi)-1:0], prev[DATA_W-1:2**gi]} : prev;
    end
  endgenerate

  assign rot_result = g_rot[LG-1].stage;

  // A rotate by a multiple of DATA_W leaves value intact, so its MSB is the carry in every case.
  always_comb begin
    result = shift_result;
    carry  = shift_carry;
    if (amount == '0) begin
      result = value;
      carry  = cin;
    end else if (sh_type == SH_ROR) begin
      result = rot_result;
      carry  = rot_result[DATA_W-1];
    end
  end

endmodule

// File: rtl/val2_shift_unit.sv
// Two-stage Val2 / shifter-carry generator with valid/ready handshakes and flush.
module val2_shift_unit
  import val2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_imm,
  input  logic              in_mem_en,
  input  logic              in_reg_shift,
  input  logic [11:0]       in_shifter,
  input  logic [DATA_W-1:0] in_rm,
  input  logic [7:0]        in_rs,
  input  logic              in_carry,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val2,
  output logic              out_carry,
  output logic [TAG_W-1:0]  out_tag
);

  s1_ctrl_t          dec_ctrl;
  logic [DATA_W-1:0] dec_value;

  s1_ctrl_t          s1_ctrl_reg;
  logic [DATA_W-1:0] s1_value_reg;
  logic [TAG_W-1:0]  s1_tag_reg;
  logic              s1_valid_reg;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_val2_reg;
  logic              out_carry_reg;
  logic [TAG_W-1:0]  out_tag_reg;

  logic              s1_adv;
  logic              s2_adv;
  logic [DATA_W-1:0] core_result;
  logic              core_carry;
  logic [DATA_W-1:0] val2_next;
  logic              carry_next;

  assign s2_adv   = !out_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  // Every form is reduced to (operand, type, amount, cin) for the shared shifter;
  // amount 0 means "pass operand through with carry = cin".
  always_comb begin
    dec_ctrl         = '0;
    dec_ctrl.mode    = decode_mode(in_mem_en, in_imm, in_reg_shift);
    dec_ctrl.cin     = in_carry;
    dec_ctrl.sh_type = in_shifter[6:5];
    dec_value        = in_rm;
    case (dec_ctrl.mode)
      MODE_MEM: begin
        dec_value        = {{(DATA_W-12){in_shifter[11]}}, in_shifter};
        dec_ctrl.sh_type = SH_LSL;
      end
      MODE_IMM: begin
        dec_value        = {{(DATA_W-8){1'b0}}, in_shifter[7:0]};
        dec_ctrl.sh_type = SH_ROR;
        dec_ctrl.amount  = AMT_W'({in_shifter[11:8], 1'b0});
      end
      MODE_REG: begin
        dec_ctrl.amount = AMT_W'(in_rs);
      end
      default: begin
        dec_ctrl.amount = AMT_W'(in_shifter[11:7]);
        if (in_shifter[11:7] == 5'd0) begin
          case (in_shifter[6:5])
            SH_LSR, SH_ASR: dec_ctrl.amount = AMT_W'(DATA_W);
            SH_ROR: begin
              // RRX: pre-rotate through the carry here, then pass straight through.
              dec_value    = {in_carry, in_rm[DATA_W-1:1]};
              dec_ctrl.cin = in_rm[0];
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  barrel_shift_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .value  (s1_value_reg),
    .amount (s1_ctrl_reg.amount),
    .sh_type(s1_ctrl_reg.sh_type),
    .cin    (s1_ctrl_reg.cin),
    .result (core_result),
    .carry  (core_carry)
  );

  assign val2_next  = (s1_ctrl_reg.mode == MODE_MEM) ? s1_value_reg : core_result;
  assign carry_next = (s1_ctrl_reg.mode == MODE_MEM) ? s1_ctrl_reg.cin : core_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_ctrl_reg   <= '0;
      s1_value_reg  <= '0;
      s1_tag_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_val2_reg  <= '0;
      out_carry_reg <= 1'b0;
      out_tag_reg   <= '0;
    end else if (flush) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_ctrl_reg  <= dec_ctrl;
          s1_value_reg <= dec_value;
          s1_tag_reg   <= in_tag;
        end
      end
      if (s2_adv) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_val2_reg  <= val2_next;
          out_carry_reg <= carry_next;
          out_tag_reg   <= s1_tag_reg;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_val2  = out_val2_reg;
  assign out_carry = out_carry_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_val2_shift_unit.sv
// Bench for val2_shift_unit: directed cases, flush, back-pressure and random streams vs a reference model.
module tb_val2_shift_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_imm, in_mem_en, in_reg_shift, in_carry, out_ready;
  logic [11:0] in_shifter;
  logic [31:0] in_rm;
  logic [7:0]  in_rs;
  logic [3:0]  in_tag;
  logic        in_ready, out_valid, out_carry;
  logic [31:0] out_val2;
  logic [3:0]  out_tag;

  val2_shift_unit #(.DATA_W(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mem_en(in_mem_en), .in_reg_shift(in_reg_shift),
    .in_shifter(in_shifter), .in_rm(in_rm), .in_rs(in_rs), .in_carry(in_carry),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_val2(out_val2),
    .out_carry(out_carry), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] val;
    logic        c;
    logic [3:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Reference: the architectural Val2 rules written out case by case; returns {carry, val2}.
  function automatic logic [32:0] ref_model(input bit imm, input bit mem, input bit regs,
                                            input logic [11:0] sh, input logic [31:0] rm,
                                            input logic [7:0] rs, input bit cin);
    int n, typ, rot;
    logic [31:0] v;
    if (mem) return {cin, {{20{sh[11]}}, sh}};
    if (imm) begin
      rot = 2 * int'(sh[11:8]);
      v = {24'd0, sh[7:0]};
      if (rot == 0) return {cin, v};
      v = (v >> rot) | (v << (32 - rot));
      return {v[31], v};
    end
    typ = int'(sh[6:5]);
    if (regs) n = int'(rs);
    else begin
      n = int'(sh[11:7]);
      if (n == 0) begin
        if (typ == 0) return {cin, rm};
        if (typ == 3) return {rm[0], cin, rm[31:1]};
        n = 32;
      end
    end
    if (n == 0) return {cin, rm};
    case (typ)
      0: begin
        if (n < 32) return {rm[32-n], rm << n};
        if (n == 32) return {rm[0], 32'd0};
        return 33'd0;
      end
      1: begin
        if (n < 32) return {rm[n-1], rm >> n};
        if (n == 32) return {rm[31], 32'd0};
        return 33'd0;
      end
      2: begin
        if (n < 32) begin
          v = $signed(rm) >>> n;
          return {rm[n-1], v};
        end
        return {rm[31], {32{rm[31]}}};
      end
      default: begin
        n = n % 32;
        if (n == 0) return {rm[31], rm};
        v = (rm >> n) | (rm << (32 - n));
        return {v[31], v};
      end
    endcase
  endfunction

  task automatic set_random_beat(input logic [3:0] tag);
    int m;
    m = $urandom_range(0, 3);
    in_mem_en    = (m == 0);
    in_imm       = (m == 1) || (m == 0 && $urandom_range(0, 1) == 1);
    in_reg_shift = (m == 2) || (m < 2 && $urandom_range(0, 1) == 1);
    in_shifter   = 12'($urandom);
    in_shifter[4] = in_reg_shift;
    in_rs        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
    in_rm        = $urandom;
    in_carry     = 1'($urandom_range(0, 1));
    in_tag       = tag;
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (exp_q.size() == 0) check({name, "_unexpected_out"}, out_valid, 0);
    else begin
      e = exp_q[0];
      check({name, "_val2"}, out_val2, e.val);
      check({name, "_carry"}, out_carry, e.c);
      check({name, "_tag"}, out_tag, e.tag);
    end
  endtask

  // One output-side observation and one input-side push per cycle; out_ready pattern 1,0,0,1 unless rnd.
  task automatic run_stream(input string name, input int ncycles, input bit rnd, input int nbeats);
    int sent = 0;
    bit stalled = 0;
    logic [32:0] r;
    for (int cyc = 0; cyc < ncycles; cyc++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (sent < nbeats && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        set_random_beat(4'(sent));
      end else in_valid = 1'b0;
      #1;
      if (stalled) check({name, "_stall_valid"}, out_valid, 1);
      stalled = 0;
      if (out_valid) begin
        check_out(name);
        if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else stalled = 1;
      end
      if (in_valid && in_ready) begin
        r = ref_model(in_imm, in_mem_en, in_reg_shift, in_shifter, in_rm, in_rs, in_carry);
        exp_q.push_back('{r[31:0], r[32], in_tag});
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      #1;
      if (out_valid) begin
        check_out(name);
        void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    check({name, "_drain_empty"}, exp_q.size(), 0);
    if (!rnd) check({name, "_beats_accepted"}, sent, nbeats);
  endtask

  logic [3:0] tag_ctr = 4'd1;

  task automatic directed(input string name, input bit imm, input bit mem, input bit regs,
                          input logic [11:0] sh, input logic [31:0] rm, input logic [7:0] rs,
                          input bit cin, input logic [31:0] exp_v, input bit exp_c);
    logic [3:0] t;
    t = tag_ctr;
    tag_ctr = tag_ctr + 4'd1;
    in_imm = imm; in_mem_en = mem; in_reg_shift = regs; in_shifter = sh;
    in_rm = rm; in_rs = rs; in_carry = cin; in_tag = t;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_lat1_valid"}, out_valid, 0);
    @(posedge clk); #1;
    check({name, "_lat2_valid"}, out_valid, 1);
    check({name, "_val2"}, out_val2, exp_v);
    check({name, "_carry"}, out_carry, exp_c);
    check({name, "_tag"}, out_tag, t);
    @(posedge clk); #1;
    $display("directed %s: val2=0x%08h carry=%0d tag=%0d", name, exp_v, exp_c, t);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = 1'b0; in_mem_en = 1'b0;
    in_reg_shift = 1'b0; in_carry = 1'b0; out_ready = 1'b1; in_shifter = '0;
    in_rm = '0; in_rs = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_val2", out_val2, 0);
    check("reset_out_carry", out_carry, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    directed("imm_rot8",   1, 0, 0, 12'h4FF, 32'h0,        8'd0,  0, 32'hFF000000, 1);
    directed("imm_rot0",   1, 0, 0, 12'h0AB, 32'h0,        8'd0,  1, 32'h000000AB, 1);
    directed("lsr0",       0, 0, 0, 12'h020, 32'h80000001, 8'd0,  0, 32'h00000000, 1);
    directed("asr0",       0, 0, 0, 12'h040, 32'h80000000, 8'd0,  0, 32'hFFFFFFFF, 1);
    directed("lsl0",       0, 0, 0, 12'h000, 32'h12345678, 8'd0,  1, 32'h12345678, 1);
    directed("rrx",        0, 0, 0, 12'h060, 32'h00000003, 8'd0,  1, 32'h80000001, 1);
    directed("reg_lsl32",  0, 0, 1, 12'h010, 32'h00000001, 8'd32, 0, 32'h00000000, 1);
    directed("reg_lsl33",  0, 0, 1, 12'h010, 32'h00000001, 8'd33, 1, 32'h00000000, 0);
    directed("reg_ror32",  0, 0, 1, 12'h070, 32'h80000001, 8'd32, 0, 32'h80000001, 1);
    directed("reg_lsr4",   0, 0, 1, 12'h030, 32'h0000001F, 8'd4,  0, 32'h00000001, 1);
    directed("mem_neg",    0, 1, 0, 12'hFFC, 32'h0,        8'd0,  0, 32'hFFFFFFFC, 0);
    directed("mem_prio",   1, 1, 1, 12'h7FF, 32'hDEADBEEF, 8'd5,  1, 32'h000007FF, 1);

    // Flush with A in the output stage, B in stage 1 and C presented on the flush cycle.
    in_imm = 1'b0; in_mem_en = 1'b1; in_reg_shift = 1'b0; in_shifter = 12'h123;
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 4'hA;
    @(posedge clk); #1;
    in_tag = 4'hB;
    @(posedge clk); #1;
    check("flush_pre_valid", out_valid, 1);
    check("flush_pre_tag", out_tag, 4'hA);
    flush = 1'b1; in_tag = 4'hC;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_out_valid", out_valid, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("flush_no_ghost", out_valid, 0);
    end
    $display("flush: tags A/B/C dropped");
    directed("post_flush", 0, 1, 0, 12'h00F, 32'h0, 8'd0, 1, 32'h0000000F, 1);

    run_stream("stream8", 24, 1'b0, 8);
    $display("stream8: 8 beats with out_ready 1,0,0,1");
    run_stream("random", 400, 1'b1, 100000);
    $display("random: 400 cycles random valid/ready");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/val2_shift_unit.md
Name: val2_shift_unit

Overview:
- Pipelined, parametrised successor to the EXE-stage Val2 generator.
- Produces the ARM data-processing second operand (Val2) and the shifter carry-out for immediate-rotate, immediate-shift, register-specified-shift and memory-offset forms, for any DATA_W.
- Two registered stages with valid/ready handshakes on both sides, plus a flush input, so it can sit between ID/EX and the ALU while hazards stall it.

Parameters:
- DATA_W, 32: operand width; power of two, >= 32.
- TAG_W, 4: width of the sideband tag carried through unchanged (destination/ROB id).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; drops both in-flight entries.
- in_valid  input  1  input beat valid.
- in_ready  output  1  the unit accepts a beat this cycle.
- in_imm  input  1  I bit.
- in_mem_en  input  1  load/store offset mode.
- in_reg_shift  input  1  bit 4 of the shifter operand; selects a register-specified shift amount.
- in_shifter  input  12  instruction shifter_operand field [11:0].
- in_rm  input  DATA_W  Rm value.
- in_rs  input  8  Rs[7:0]; the register shift amount.
- in_carry  input  1  current C flag.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_val2  output  DATA_W  Val2.
- out_carry  output  1  shifter carry-out.
- out_tag  output  TAG_W  tag.

Behaviour:
- Reset: s1_valid, out_valid, out_val2, out_carry and out_tag are all 0. in_ready is 1 in the first cycle after reset.
- Stage 1 registers the decoded mode, amount, type, Rm, carry and tag.
- Stage 2 computes the shift and registers out_val2, out_carry, out_valid and out_tag.
- Latency: exactly 2 cycles from the in_valid&&in_ready edge to out_valid, when there are no stalls. Throughput is 1 beat per cycle.
- Flow control:
  - s2_adv = !out_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv, purely combinational; no combinational path from in_valid to any output.
- While out_valid && !out_ready, out_val2, out_carry and out_tag hold stable. There is no loss and no duplication under back-pressure.
- flush: s1_valid and out_valid are cleared next cycle, and any beat presented in the same cycle is dropped. flush has priority over normal advance. rst has priority over flush.
- Mode priority is mem_en > imm > reg_shift > immediate shift.
- mem_en:
  - Val2 = sign-extended shifter[11:0].
  - carry = in_carry.
- imm:
  - Val2 = zero-extended shifter[7:0], rotated right by (2*shifter[11:8]) mod DATA_W.
  - carry = in_carry if the rotate amount is 0, else Val2[DATA_W-1].
- Immediate shift: n = shifter[11:7]; type = shifter[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - LSL #0: Rm, carry = in_carry.
  - LSR #0 is treated as LSR #DATA_W: result 0, carry = Rm[DATA_W-1].
  - ASR #0 is treated as ASR #DATA_W: result = all bits Rm[DATA_W-1], carry = Rm[DATA_W-1].
  - ROR #0 is RRX: Val2 = {in_carry, Rm[DATA_W-1:1]}, carry = Rm[0].
  - Otherwise (n != 0) the shift is n, using the register-shift rules below.
- Register shift: n = in_rs[7:0], type = shifter[6:5].
  - n==0: Rm, carry = in_carry.
  - LSL:
    - n<DATA_W: Rm<<n, carry = Rm[DATA_W-n].
    - n==DATA_W: 0, carry = Rm[0].
    - n>DATA_W: 0, carry 0.
  - LSR:
    - n<DATA_W: Rm>>n, carry = Rm[n-1].
    - n==DATA_W: 0, carry = Rm[DATA_W-1].
    - n>DATA_W: 0, carry 0.
  - ASR:
    - n<DATA_W: arithmetic shift, carry = Rm[n-1].
    - n>=DATA_W: all bits Rm[DATA_W-1], carry = Rm[DATA_W-1].
  - ROR:
    - n mod DATA_W == 0: Rm, carry = Rm[DATA_W-1].
    - Otherwise rotate by n mod DATA_W, carry = Val2[DATA_W-1].
- All shifts are single-cycle combinational logic in stage 2. No loops whose bounds depend on data; use a log2(DATA_W)-level barrel shifter.

Decomposition:
- Shared package val2_pkg holds:
  - shift type localparams SH_LSL/SH_LSR/SH_ASR/SH_ROR;
  - mode encodings MODE_MEM/MODE_IMM/MODE_REG/MODE_ISH;
  - the decoded stage-1 record layout.
- One combinational sub-module, barrel_shift_core (DATA_W), takes value, amount[7:0], type and cin, and returns result and carry. Stage 2 instantiates it; the stage-1 decode maps the immediate-rotate and #0 special cases onto it.

Test Plan:
- Reset, then the first cycle: out_valid=0, out_val2=0, out_carry=0, in_ready=1.
- imm=1, shifter=12'h4FF (rotate by 8), DATA_W=32 -> out_val2=32'hFF000000, carry=1, two cycles after acceptance.
- Immediate shift LSR #0 (shifter=12'h020), Rm=32'h80000001 -> Val2=0, carry=1.
- ROR #0 (RRX, shifter=12'h060), Rm=32'h00000003, in_carry=1 -> Val2=32'h80000001, carry=1.
- Register LSL, in_rs=32, Rm=32'h00000001 -> 0 with carry=1; same with in_rs=33 -> 0 with carry=0.
- mem_en=1, shifter=12'hFFC -> Val2=32'hFFFFFFFC.
- Streaming 8 beats with out_ready toggled 1,0,0,1 -> outputs in order, no drops, outputs stable while stalled.
- flush asserted with two beats in flight -> out_valid=0 next cycle and neither tag ever appears.
